task_dispatch_scheduler: RTL
============================

TASK_DISPATCH_SCHEDULER -- requirements
Module: task_dispatch_scheduler

Interface
REQ-001 The block SHALL have parameter REGISTER_AMOUNT, default 32, the number of architectural registers tracked.
REQ-002 The block SHALL have parameter REG_CTN_WIDTH, default $clog2(REGISTER_AMOUNT), the register index width.
REQ-003 The block SHALL have port clk, input, 1, the clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1, a dispatch request is present.
REQ-006 The block SHALL have port req_ready, output, 1, the request is accepted this cycle when req_valid is also high.
REQ-007 The block SHALL have ports req_rd, req_rs1 and req_rs2, input, REG_CTN_WIDTH each, the destination and source register indices.
REQ-008 The block SHALL have port req_force_main, input, 1, the request may only go to processor 1.
REQ-009 The block SHALL have ports processor_idle_1 and processor_idle_2, input, 1 each, the processor-idle status.
REQ-010 The block SHALL have ports boot_renew_register_1 and boot_renew_register_2, output, 1 each, single-cycle start pulses.
REQ-011 The block SHALL have port register_num, output, REG_CTN_WIDTH, the destination index of the current boot pulse.
REQ-012 The block SHALL have port busy_mask, output, REGISTER_AMOUNT, the scoreboard, where bit i = register i pending.
REQ-013 The block SHALL have port sched_idle, output, 1, high when both processors are in IDLE and busy_mask is 0.

Function
REQ-014 The block SHALL keep one FSM per processor with states IDLE, BOOT and RUN.
REQ-015 A processor SHALL be free only when its FSM is in IDLE and its processor_idle input is 1.
REQ-016 A hazard SHALL exist when busy_mask[req_rs1], busy_mask[req_rs2] or busy_mask[req_rd] is 1 (RAW and WAW); index 0 SHALL never be busy.
REQ-017 Processor 1 SHALL be selected if free; otherwise processor 2 SHALL be selected if free and req_force_main=0; otherwise there is no selection.
REQ-018 req_ready SHALL be combinational: high iff there is no hazard and a processor is selected; req_ready is independent of req_valid.
REQ-019 On acceptance (req_valid & req_ready), the selected FSM SHALL move IDLE->BOOT, latch req_rd, and set busy_mask[req_rd] at the next edge unless req_rd=0.
REQ-020 In BOOT, the FSM SHALL drive its boot_renew_register_x=1 and register_num=latched rd for exactly one cycle, then move to RUN.
REQ-021 Boot latency SHALL be 1 cycle: the pulse appears in the cycle after acceptance.
REQ-022 The block SHALL detect a rising edge on each processor_idle with a registered previous value, which is updated every cycle.
REQ-023 In RUN, on the rising edge of its processor_idle, the FSM SHALL clear busy_mask[latched rd] and return to IDLE.
REQ-024 Hazard checks SHALL use the registered busy_mask with no same-cycle bypass, so a cleared register becomes dispatchable one cycle after its completion edge.
REQ-025 When both processors complete in the same cycle, both bits SHALL clear.
REQ-026 When a set and a clear of busy_mask occur in the same cycle, each SHALL apply to its own bit; the same bit cannot be set and cleared in one cycle because of the WAW check.
REQ-027 register_num SHALL be 0 when no boot pulse is active.
REQ-028 At most one boot pulse SHALL occur per cycle.

Reset
REQ-029 On rst_n=0, both FSMs SHALL go to IDLE, busy_mask=0, boot_renew_register_1=boot_renew_register_2=0, register_num=0, and the edge registers=1.
REQ-030 Reset asserted mid-operation SHALL abandon in-flight tasks with no completion clear pending afterward.
REQ-031 After reset, the outputs SHALL be req_ready=1 only if processor_idle_1 or processor_idle_2 is high, and sched_idle=1.

Configuration
REQ-032 With macro STALL_COUNTER_EN defined, the block SHALL add output stall_cnt, 16 bits, which increments each cycle req_valid=1 and req_ready=0, saturates at 0xFFFF, and is reset to 0.
REQ-033 Without STALL_COUNTER_EN, the port and the counter SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-034 Both processors idle, request rd=5, rs=2/3 -> accepted; next cycle boot_renew_register_1=1 and register_num=5; busy_mask[5]=1.
REQ-035 Processor 1 in RUN, request rd=7, force_main=0 -> processor 2 booted with register_num=7; with force_main=1 -> req_ready=0 until processor 1 completes.
REQ-036 busy_mask[5]=1, request rs1=5 -> req_ready=0; processor_idle_1 rises -> busy_mask[5]=0 on that edge, and req_ready=1 the following cycle.
REQ-037 Both processors complete in the same cycle (rd 4 and 9) -> bits 4 and 9 clear together, and sched_idle=1 the next cycle.
REQ-038 rd=0 dispatch -> boot pulse issued and busy_mask stays 0; rst_n pulsed during RUN -> all outputs reach reset values asynchronously.
REQ-039 With STALL_COUNTER_EN, 3 stalled valid cycles -> stall_cnt=3; preloaded near saturation -> holds at 0xFFFF.

Source files
------------

// File: rtl/task_dispatch_scheduler.sv
// task_dispatch_scheduler
// Dispatches register-tagged tasks to two processors. Each processor has an
// IDLE/BOOT/RUN FSM; a register scoreboard (busy_mask) blocks RAW and WAW
// hazards until the owning processor signals completion via a rising edge
// on its processor_idle input.
// Optional feature macro: STALL_COUNTER_EN adds a saturating 16-bit
// stall_cnt output counting cycles with req_valid=1 and req_ready=0.
module task_dispatch_scheduler #(
    parameter int REGISTER_AMOUNT = 32,
    parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [REG_CTN_WIDTH-1:0]   req_rd,
    input  logic [REG_CTN_WIDTH-1:0]   req_rs1,
    input  logic [REG_CTN_WIDTH-1:0]   req_rs2,
    input  logic                       req_force_main,
    input  logic                       processor_idle_1,
    input  logic                       processor_idle_2,
    output logic                       boot_renew_register_1,
    output logic                       boot_renew_register_2,
    output logic [REG_CTN_WIDTH-1:0]   register_num,
    output logic [REGISTER_AMOUNT-1:0] busy_mask,
    output logic                       sched_idle
`ifdef STALL_COUNTER_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } fsm_state_t;

    // One-hot vector with a single bit set at register index idx.
    function automatic logic [REGISTER_AMOUNT-1:0] idx_onehot(input logic [REG_CTN_WIDTH-1:0] idx);
        logic [REGISTER_AMOUNT-1:0] v;
        v      = {REGISTER_AMOUNT{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    fsm_state_t                 state1_r, state2_r;
    fsm_state_t                 state1_s, state2_s;
    logic [REG_CTN_WIDTH-1:0]   rd1_r, rd2_r;
    logic                       prev_idle1_r, prev_idle2_r;
    logic [REGISTER_AMOUNT-1:0] busy_r, busy_s;
    logic                       boot1_r, boot2_r;
    logic [REG_CTN_WIDTH-1:0]   regnum_r;
    logic                       sched_idle_r;

    logic free1_s, free2_s, hazard_s, sel1_s, sel2_s, ready_s;
    logic accept1_s, accept2_s, rise1_s, rise2_s, clr1_s, clr2_s;
    logic [REGISTER_AMOUNT-1:0] set_mask_s, clr_mask_s;

    // Request qualification: hazard checks use only the registered scoreboard.
    assign free1_s   = (state1_r == ST_IDLE) && processor_idle_1;
    assign free2_s   = (state2_r == ST_IDLE) && processor_idle_2;
    assign hazard_s  = busy_r[req_rs1] | busy_r[req_rs2] | busy_r[req_rd];
    assign sel1_s    = free1_s;
    assign sel2_s    = !free1_s && free2_s && !req_force_main;
    assign ready_s   = !hazard_s && (sel1_s || sel2_s);
    assign accept1_s = req_valid && ready_s && sel1_s;
    assign accept2_s = req_valid && ready_s && sel2_s;

    // Completion is a rising edge of processor_idle seen while in RUN.
    assign rise1_s = processor_idle_1 && !prev_idle1_r;
    assign rise2_s = processor_idle_2 && !prev_idle2_r;
    assign clr1_s  = (state1_r == ST_RUN) && rise1_s;
    assign clr2_s  = (state2_r == ST_RUN) && rise2_s;

    // Next-state logic for both processor FSMs.
    always_comb begin
        state1_s = state1_r;
        state2_s = state2_r;
        case (state1_r)
            ST_IDLE: state1_s = accept1_s ? ST_BOOT : ST_IDLE;
            ST_BOOT: state1_s = ST_RUN;
            ST_RUN:  state1_s = clr1_s ? ST_IDLE : ST_RUN;
            default: state1_s = ST_IDLE;
        endcase
        case (state2_r)
            ST_IDLE: state2_s = accept2_s ? ST_BOOT : ST_IDLE;
            ST_BOOT: state2_s = ST_RUN;
            ST_RUN:  state2_s = clr2_s ? ST_IDLE : ST_RUN;
            default: state2_s = ST_IDLE;
        endcase
    end

    // Scoreboard update: completions clear their own bit, an accepted non-zero rd sets its bit.
    always_comb begin
        set_mask_s = {REGISTER_AMOUNT{1'b0}};
        clr_mask_s = {REGISTER_AMOUNT{1'b0}};
        if ((accept1_s || accept2_s) && (req_rd != {REG_CTN_WIDTH{1'b0}})) begin
            set_mask_s = idx_onehot(req_rd);
        end else begin
            set_mask_s = {REGISTER_AMOUNT{1'b0}};
        end
        if (clr1_s) begin
            clr_mask_s = clr_mask_s | idx_onehot(rd1_r);
        end else begin
            clr_mask_s = clr_mask_s;
        end
        if (clr2_s) begin
            clr_mask_s = clr_mask_s | idx_onehot(rd2_r);
        end else begin
            clr_mask_s = clr_mask_s;
        end
        busy_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~idx_onehot({REG_CTN_WIDTH{1'b0}});
    end

    // FSM state, latched destinations and idle-edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1_r     <= ST_IDLE;
            state2_r     <= ST_IDLE;
            rd1_r        <= {REG_CTN_WIDTH{1'b0}};
            rd2_r        <= {REG_CTN_WIDTH{1'b0}};
            prev_idle1_r <= 1'b1;
            prev_idle2_r <= 1'b1;
            busy_r       <= {REGISTER_AMOUNT{1'b0}};
        end else begin
            state1_r     <= state1_s;
            state2_r     <= state2_s;
            rd1_r        <= accept1_s ? req_rd : rd1_r;
            rd2_r        <= accept2_s ? req_rd : rd2_r;
            prev_idle1_r <= processor_idle_1;
            prev_idle2_r <= processor_idle_2;
            busy_r       <= busy_s;
        end
    end

    // Registered boot pulses, boot register index and scheduler-idle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot1_r      <= 1'b0;
            boot2_r      <= 1'b0;
            regnum_r     <= {REG_CTN_WIDTH{1'b0}};
            sched_idle_r <= 1'b1;
        end else begin
            boot1_r      <= accept1_s;
            boot2_r      <= accept2_s;
            regnum_r     <= (accept1_s || accept2_s) ? req_rd : {REG_CTN_WIDTH{1'b0}};
            sched_idle_r <= (state1_s == ST_IDLE) && (state2_s == ST_IDLE) &&
                            (busy_s == {REGISTER_AMOUNT{1'b0}});
        end
    end

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where a request waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (req_valid && !ready_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign req_ready             = ready_s;
    assign boot_renew_register_1 = boot1_r;
    assign boot_renew_register_2 = boot2_r;
    assign register_num          = regnum_r;
    assign busy_mask             = busy_r;
    assign sched_idle            = sched_idle_r;

endmodule
